inst_fetch_unit: RTL and testbench
==================================

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000; first fetch address after reset.
REQ-002 Parameter DEPTH, default 2; prefetch FIFO entries, legal values 2..4.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 freeze  in  1  downstream stall; the head entry is not consumed.
REQ-006 branchTaken  in  1  redirect request from execute.
REQ-007 branchAddr  in  32  redirect target; bits [1:0] are ignored and treated as 0.
REQ-008 memReq  out  1  instruction-memory request.
REQ-009 memAddr  out  32  word address of the request.
REQ-010 memReady  in  1  one-cycle pulse; memData is valid in that cycle.
REQ-011 memData  in  32  fetched instruction word.
REQ-012 instValid  out  1  head of FIFO is valid.
REQ-013 instruction  out  32  head instruction word, 0 when instValid=0.
REQ-014 pc  out  32  head fetch address + 4, 0 when instValid=0; feeds the IF/ID register.

Function
REQ-015 The block SHALL keep fetchPc (32b), a DEPTH-entry FIFO of {instruction, pc}, a count, and a 3-state FSM: IDLE, REQ, DROP.
REQ-016 memReq SHALL be 1 exactly in REQ and DROP; memAddr SHALL equal fetchPc in REQ and SHALL hold the abandoned address in DROP.
REQ-017 memAddr SHALL stay stable while memReq=1 and memReady=0.
REQ-018 IDLE->REQ SHALL occur when count<DEPTH and branchTaken=0.
REQ-019 In REQ with memReady=1, the block SHALL push {memData, fetchPc+4} and set fetchPc<=fetchPc+4.
REQ-020 After that push, the FSM SHALL stay in REQ if count_next<DEPTH, otherwise go to IDLE; requests then run back-to-back with no bubble.
REQ-021 A push SHALL never meet a full FIFO; if it does, this is an assertion failure.
REQ-022 Pop SHALL occur when instValid=1, freeze=0 and branchTaken=0; at most one pop per cycle.
REQ-023 Simultaneous push and pop SHALL leave count unchanged.
REQ-024 Push data SHALL become visible on outputs the next cycle (memReady at t -> instValid at t+1 if the FIFO was empty).
REQ-025 When branchTaken=1, the FIFO SHALL be emptied the same edge and fetchPc<=branchAddr&~3; branchTaken has priority over freeze, push and pop.
REQ-026 Branch in REQ with memReady=0 -> DROP; in DROP, memReady SHALL be discarded and the FSM goes to REQ at fetchPc.
REQ-027 Branch in REQ with memReady=1 -> the response SHALL be discarded and the FSM goes to REQ at branchAddr next cycle.
REQ-028 Branch in IDLE -> REQ at branchAddr next cycle.
REQ-029 Branch in DROP -> stay in DROP, with fetchPc updated to the newest target.
REQ-030 fetchPc SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-031 Freeze SHALL NOT stop fetching; requests continue until the FIFO plus the outstanding request fill DEPTH.

Reset
REQ-032 While rst_n=0: FSM=IDLE, fetchPc=RESET_PC, count=0, memReq=0, instValid=0, instruction=0, pc=0.
REQ-033 First edge with rst_n=1: memReq=1, memAddr=RESET_PC.
REQ-034 Reset asserted mid-request SHALL abandon the request immediately; a memReady arriving during or after reset with no new request SHALL be ignored.

Verification
REQ-035 Reset release, memory answers 1 cycle after each request -> memAddr sequence 0,4,8; outputs pc=4,8,12 with the matching words, instValid continuous after the first fill.
REQ-036 freeze=1 for 6 cycles (DEPTH=2) -> exactly 2 words buffered, memReq=0, head instruction/pc held; freeze=0 -> in-order drain with no loss or duplication.
REQ-037 branchTaken with branchAddr=32'h103 while a request to 8 is pending, memReady 3 cycles later -> that response dropped, next memAddr=32'h100, first valid pc=32'h104.
REQ-038 branchTaken in the same cycle as memReady and freeze=1 -> FIFO empty next cycle, instValid=0, memAddr=branchAddr.
REQ-039 RESET_PC=32'hFFFF_FFFC -> first pc output 0, second fetch memAddr=0.
REQ-040 rst_n pulsed low while memReq=1, with memReady arriving 1 cycle after release -> no push, memAddr=RESET_PC.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: prefetches words into a DEPTH-entry FIFO and presents the head to decode.
// Latency: memReady in cycle t makes the word visible at the head in cycle t+1 (empty FIFO).
// Backpressure: freeze only holds the head; fetching continues until FIFO plus outstanding request fill DEPTH.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        branchTaken,
  input  logic [31:0] branchAddr,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memReady,
  input  logic [31:0] memData,
  output logic        instValid,
  output logic [31:0] instruction,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2} state_t;

  localparam logic [2:0] DEPTH_C  = 3'(DEPTH);
  localparam logic [1:0] LAST_IDX = 2'(DEPTH - 1);

  state_t      state, state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] drop_addr;
  logic [31:0] branch_tgt;
  // storage sized for the largest legal DEPTH; only DEPTH entries are ever addressed
  logic [31:0] fifo_inst [4];
  logic [31:0] fifo_pc   [4];
  logic [1:0]  rd_ptr, wr_ptr;
  logic [2:0]  count, count_nxt;
  logic        push, pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
  endfunction

  // a branch overrides everything: no push of the in-flight word, no pop of the head
  assign branch_tgt = branchAddr & ~32'd3;
  assign push       = (state == REQ) && memReady && !branchTaken;
  assign pop        = (count != 3'd0) && !freeze && !branchTaken;

  // occupancy after the coming edge; simultaneous push and pop cancel
  always_comb begin
    count_nxt = count;
    if (branchTaken) count_nxt = 3'd0;
    else             count_nxt = count + 3'(push) - 3'(pop);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: only one request is ever outstanding
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (branchTaken || (count < DEPTH_C)) state_nxt = REQ;
      REQ: begin
        if (branchTaken)   state_nxt = memReady ? REQ : DROP;
        else if (memReady) state_nxt = (count_nxt < DEPTH_C) ? REQ : IDLE;
      end
      // the abandoned response must still be absorbed; a branch here only retargets fetch_pc
      DROP: if (memReady) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: the address is held on the abandoned request until it completes
  always_comb begin
    memReq  = (state != IDLE);
    memAddr = (state == DROP) ? drop_addr : fetch_pc;
  end

  // fetch address and abandoned-request address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      drop_addr <= RESET_PC;
    end else begin
      if (branchTaken)  fetch_pc <= branch_tgt;
      else if (push)    fetch_pc <= fetch_pc + 32'd4;
      if ((state == REQ) && branchTaken && !memReady) drop_addr <= fetch_pc;
    end
  end

  // FIFO pointers and occupancy; a branch empties the FIFO in one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      count <= count_nxt;
      if (branchTaken) begin
        rd_ptr <= 2'd0;
        wr_ptr <= 2'd0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  // FIFO storage: the stored pc is the address following the fetched word
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= memData;
      fifo_pc[wr_ptr]   <= fetch_pc + 32'd4;
    end
  end

  // head presentation, zeroed when empty
  always_comb begin
    instValid   = (count != 3'd0);
    instruction = instValid ? fifo_inst[rd_ptr] : 32'd0;
    pc          = instValid ? fifo_pc[rd_ptr]   : 32'd0;
  end

  // request throttling must make a push into a full FIFO impossible
  assert property (@(posedge clk) disable iff (!rst_n) !(push && (count == DEPTH_C)));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: scoreboard of expected {instruction, pc} pairs.
// Expectations are queued when a memory response is driven and compared on each pop.
// Covers reset, streaming, freeze, branch in REQ/DROP, reset mid-request and pc wrap.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, freeze, branchTaken, memReady;
  logic [31:0] branchAddr, memData;
  logic        memReq, instValid;
  logic [31:0] memAddr, instruction, pc;

  logic        rst2_n, ready2;
  logic [31:0] data2;
  logic        memReq2, instValid2;
  logic [31:0] memAddr2, instruction2, pc2;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] sb[$];
  logic [63:0] sb_head;
  logic [31:0] exp_addr;
  bit          auto_en = 1'b0;
  bit          auto_drove = 1'b0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .branchTaken(branchTaken),
    .branchAddr(branchAddr), .memReq(memReq), .memAddr(memAddr),
    .memReady(memReady), .memData(memData), .instValid(instValid),
    .instruction(instruction), .pc(pc)
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_wrap (
    .clk(clk), .rst_n(rst2_n), .freeze(1'b0), .branchTaken(1'b0),
    .branchAddr(32'd0), .memReq(memReq2), .memAddr(memAddr2),
    .memReady(ready2), .memData(data2), .instValid(instValid2),
    .instruction(instruction2), .pc(pc2)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hC0DE_0001 ^ (a << 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // automatic memory: answers in the same cycle the request is seen
  initial begin
    forever begin
      @(posedge clk); #1;
      if (auto_drove) begin
        memReady   = 1'b0;
        auto_drove = 1'b0;
      end
      if (auto_en && memReq) begin
        check("req_addr", memAddr, exp_addr);
        memReady = 1'b1;
        memData  = word_of(memAddr);
        sb.push_back({word_of(exp_addr), exp_addr + 32'd4});
        exp_addr   = exp_addr + 32'd4;
        auto_drove = 1'b1;
      end
    end
  end

  // consumer side: every pop must match the oldest expected entry
  always @(negedge clk) begin
    if (mon_en && instValid && !freeze && !branchTaken) begin
      if (sb.size() == 0) begin
        check("pop_unexpected", {31'd0, instValid}, 32'd0);
      end else begin
        sb_head = sb.pop_front();
        check("pop_inst", instruction, sb_head[63:32]);
        check("pop_pc", pc, sb_head[31:0]);
      end
    end
  end

  // manual single response, called just after a rising edge
  task automatic mem_reply(input logic [31:0] a, input bit keep);
    check("req_addr_m", memAddr, a);
    memReady = 1'b1;
    memData  = word_of(a);
    if (keep) sb.push_back({word_of(a), a + 32'd4});
    @(posedge clk); #1;
    memReady = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    @(negedge clk);
    while (!instValid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, instValid}, 32'd1);
  endtask

  // returns just after the edge that moves the FSM into REQ at RESET_PC
  task automatic do_reset();
    mon_en = 1'b0; auto_en = 1'b0;
    rst_n = 1'b0; memReady = 1'b0; freeze = 1'b0; branchTaken = 1'b0;
    branchAddr = 32'd0; memData = 32'd0;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_memReq", {31'd0, memReq}, 32'd0);
    check("rst_instValid", {31'd0, instValid}, 32'd0);
    check("rst_instruction", instruction, 32'd0);
    check("rst_pc", pc, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_addr = 32'd0;
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    rst2_n = 1'b0; ready2 = 1'b0; data2 = 32'd0;

    // streaming after reset
    do_reset();
    @(negedge clk);
    check("first_memReq", {31'd0, memReq}, 32'd1);
    check("first_memAddr", memAddr, 32'd0);
    exp_addr = 32'd0;
    auto_en  = 1'b1;
    wait_valid("stream_valid");
    check("stream_first_pc", pc, 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stream_continuous", {31'd0, instValid}, 32'd1);
    end

    // freeze: fetch fills the FIFO, head holds, then drains in order
    @(posedge clk); #1;
    freeze = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("frz_head_inst", instruction, sb[0][63:32]);
      check("frz_head_pc", pc, sb[0][31:0]);
    end
    check("frz_memReq", {31'd0, memReq}, 32'd0);
    check("frz_buffered", sb.size(), 32'd2);
    @(posedge clk); #1;
    freeze = 1'b0;
    repeat (10) @(negedge clk);
    auto_en = 1'b0;
    repeat (4) @(negedge clk);
    check("drain_complete", sb.size(), 32'd0);

    // branch while a request is pending: response dropped later
    do_reset();
    mem_reply(32'd0, 1'b1);
    mem_reply(32'd4, 1'b1);
    check("pending_addr", memAddr, 32'd8);
    branchTaken = 1'b1;
    branchAddr  = 32'h0000_0103;
    sb.delete();
    @(posedge clk); #1;
    branchTaken = 1'b0;
    @(negedge clk);
    check("drop_memReq", {31'd0, memReq}, 32'd1);
    check("drop_addr_held", memAddr, 32'd8);
    check("drop_flushed", {31'd0, instValid}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    memReady = 1'b1;
    memData  = word_of(32'd8);
    @(posedge clk); #1;
    memReady = 1'b0;
    @(negedge clk);
    check("redirect_addr", memAddr, 32'h0000_0100);
    check("redirect_no_push", {31'd0, instValid}, 32'd0);
    exp_addr = 32'h0000_0100;
    auto_en  = 1'b1;
    wait_valid("redirect_valid");
    check("redirect_first_pc", pc, 32'h0000_0104);
    auto_en = 1'b0;
    repeat (3) @(negedge clk);

    // branch coinciding with memReady and freeze
    do_reset();
    mem_reply(32'd0, 1'b1);
    memReady    = 1'b1;
    memData     = word_of(32'd4);
    branchTaken = 1'b1;
    branchAddr  = 32'h0000_0200;
    freeze      = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    memReady = 1'b0; branchTaken = 1'b0; freeze = 1'b0;
    @(negedge clk);
    check("brr_instValid", {31'd0, instValid}, 32'd0);
    check("brr_instruction", instruction, 32'd0);
    check("brr_pc", pc, 32'd0);
    check("brr_memReq", {31'd0, memReq}, 32'd1);
    check("brr_memAddr", memAddr, 32'h0000_0200);

    // reset pulse mid-request with a stray response around release
    @(posedge clk); #1;
    rst_n    = 1'b0;
    memReady = 1'b1;
    memData  = 32'hBAD0_BAD0;
    #2;
    check("midrst_memReq", {31'd0, memReq}, 32'd0);
    check("midrst_instValid", {31'd0, instValid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    memReady = 1'b0;
    @(negedge clk);
    check("midrst_req_again", {31'd0, memReq}, 32'd1);
    check("midrst_addr", memAddr, 32'd0);
    check("midrst_no_push", {31'd0, instValid}, 32'd0);
    @(negedge clk);
    check("midrst_still_empty", {31'd0, instValid}, 32'd0);
    mon_en = 1'b0;

    // fetch address wraps from the top of the address space
    @(negedge clk);
    check("wrap_rst_memReq", {31'd0, memReq2}, 32'd0);
    check("wrap_rst_instValid", {31'd0, instValid2}, 32'd0);
    @(posedge clk); #1;
    rst2_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("wrap_memReq", {31'd0, memReq2}, 32'd1);
    check("wrap_first_addr", memAddr2, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    ready2 = 1'b1;
    data2  = word_of(32'hFFFF_FFFC);
    @(posedge clk); #1;
    ready2 = 1'b0;
    @(negedge clk);
    check("wrap_instValid", {31'd0, instValid2}, 32'd1);
    check("wrap_pc", pc2, 32'd0);
    check("wrap_inst", instruction2, word_of(32'hFFFF_FFFC));
    check("wrap_second_addr", memAddr2, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
